// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder with ID/CTRL/SCRATCH/COUNT registers; CTRL drives test pins and LED.
// Optional byte-strobe support: define AXIL_REG_RESPONDER_WSTRB_EN.
module axil_reg_responder #(
   parameter int                AWIDTH   = 8,
   parameter int                DWIDTH   = 16,
   parameter logic [DWIDTH-1:0] ID_VALUE = 16'hF1D5
) (
   input  logic                  i_CLK,
   input  logic                  i_RESET_n,
   input  logic [AWIDTH-1:0]     iv_AWADDR,
   input  logic                  i_AWVALID,
   output logic                  o_AWREADY,
   input  logic [DWIDTH-1:0]     iv_WDATA,
   input  logic [DWIDTH/8-1:0]   iv_WSTRB,
   input  logic                  i_WVALID,
   output logic                  o_WREADY,
   output logic [1:0]            ov_BRESP,
   output logic                  o_BVALID,
   input  logic                  i_BREADY,
   input  logic [AWIDTH-1:0]     iv_ARADDR,
   input  logic                  i_ARVALID,
   output logic                  o_ARREADY,
   output logic [DWIDTH-1:0]     ov_RDATA,
   output logic [1:0]            ov_RRESP,
   output logic                  o_RVALID,
   input  logic                  i_RREADY,
   output logic [7:0]            ov_FPGA_TEST,
   output logic                  o_LED
);
   localparam int         SWIDTH      = DWIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] IDX_ID      = 2'd0;
   localparam logic [1:0] IDX_CTRL    = 2'd1;
   localparam logic [1:0] IDX_SCRATCH = 2'd2;
   localparam logic [1:0] IDX_COUNT   = 2'd3;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t            w_state_reg, w_state_next;
   r_state_t            r_state_reg, r_state_next;
   logic                aw_held_reg, aw_held_next;
   logic                w_held_reg, w_held_next;
   logic [AWIDTH-1:0]   awaddr_reg, awaddr_next;
   logic [DWIDTH-1:0]   wdata_reg, wdata_next;
   logic [1:0]          bresp_reg, bresp_next;
   logic                awready_reg, awready_next;
   logic                wready_reg, wready_next;
   logic                arready_reg, arready_next;
   logic [DWIDTH-1:0]   rdata_reg, rdata_next;
   logic [1:0]          rresp_reg, rresp_next;
   logic [8:0]          ctrl_reg, ctrl_next;
   logic [DWIDTH-1:0]   scratch_reg, scratch_next;
   logic [DWIDTH-1:0]   count_reg;

   logic                aw_hs, w_hs, ar_hs, do_write;
   logic [AWIDTH-1:0]   wr_addr_eff;
   logic [DWIDTH-1:0]   wr_data_eff;
   logic [DWIDTH-1:0]   wmask;
   logic                wr_mapped, rd_mapped;
   logic [1:0]          wr_idx, rd_idx;

   assign aw_hs       = awready_reg & i_AWVALID;
   assign w_hs        = wready_reg & i_WVALID;
   assign ar_hs       = arready_reg & i_ARVALID;
   // A channel already held wins; otherwise the beat handshaking this cycle is used directly.
   assign wr_addr_eff = aw_held_reg ? awaddr_reg : iv_AWADDR;
   assign wr_data_eff = w_held_reg ? wdata_reg : iv_WDATA;
   assign wr_mapped   = (wr_addr_eff[AWIDTH-1:3] == '0);
   assign wr_idx      = wr_addr_eff[2:1];
   assign rd_mapped   = (iv_ARADDR[AWIDTH-1:3] == '0);
   assign rd_idx      = iv_ARADDR[2:1];

`ifdef AXIL_REG_RESPONDER_WSTRB_EN
   logic [SWIDTH-1:0]   wstrb_reg, wstrb_next;
   logic [SWIDTH-1:0]   wr_strb_eff;
   logic                unused_addr;
   assign wr_strb_eff = w_held_reg ? wstrb_reg : iv_WSTRB;
   assign wstrb_next  = w_hs ? iv_WSTRB : wstrb_reg;
   assign unused_addr = wr_addr_eff[0] ^ iv_ARADDR[0];
   for (genvar gi = 0; gi < SWIDTH; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wr_strb_eff[gi]}};
   end
   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) wstrb_reg <= '0;
      else            wstrb_reg <= wstrb_next;
   end
`else
   logic unused_bits;
   assign unused_bits = ^{iv_WSTRB, wr_addr_eff[0], iv_ARADDR[0]};
   assign wmask       = '1;
`endif

   always_comb begin
      w_state_next = w_state_reg;
      aw_held_next = aw_held_reg;
      w_held_next  = w_held_reg;
      awaddr_next  = awaddr_reg;
      wdata_next   = wdata_reg;
      bresp_next   = bresp_reg;
      do_write     = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_next = 1'b1;
               awaddr_next  = iv_AWADDR;
            end
            if (w_hs) begin
               w_held_next = 1'b1;
               wdata_next  = iv_WDATA;
            end
            if (aw_held_next && w_held_next) begin
               aw_held_next = 1'b0;
               w_held_next  = 1'b0;
               w_state_next = W_RESP;
               do_write     = wr_mapped && (wr_idx == IDX_CTRL || wr_idx == IDX_SCRATCH);
               bresp_next   = do_write ? RESP_OKAY : RESP_SLVERR;
            end
         end
         W_RESP: begin
            if (i_BREADY) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
      awready_next = (w_state_next == W_IDLE) && !aw_held_next;
      wready_next  = (w_state_next == W_IDLE) && !w_held_next;

      ctrl_next    = ctrl_reg;
      scratch_next = scratch_reg;
      if (do_write && wr_idx == IDX_CTRL)
         ctrl_next = (ctrl_reg & ~wmask[8:0]) | (wr_data_eff[8:0] & wmask[8:0]);
      if (do_write && wr_idx == IDX_SCRATCH)
         scratch_next = (scratch_reg & ~wmask) | (wr_data_eff & wmask);
   end

   // Read data is sampled from current register values, so a same-edge write is not visible.
   always_comb begin
      r_state_next = r_state_reg;
      rdata_next   = rdata_reg;
      rresp_next   = rresp_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_next = R_DATA;
               rresp_next   = rd_mapped ? RESP_OKAY : RESP_SLVERR;
               rdata_next   = '0;
               if (rd_mapped) begin
                  case (rd_idx)
                     IDX_ID:      rdata_next = ID_VALUE;
                     IDX_CTRL:    rdata_next = {{(DWIDTH-9){1'b0}}, ctrl_reg};
                     IDX_SCRATCH: rdata_next = scratch_reg;
                     default:     rdata_next = count_reg;
                  endcase
               end
            end
         end
         R_DATA: begin
            if (i_RREADY) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
      arready_next = (r_state_next == R_IDLE);
   end

   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         w_state_reg <= W_IDLE;
         r_state_reg <= R_IDLE;
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         awaddr_reg  <= '0;
         wdata_reg   <= '0;
         bresp_reg   <= RESP_OKAY;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         arready_reg <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
         ctrl_reg    <= '0;
         scratch_reg <= '0;
         count_reg   <= '0;
      end else begin
         w_state_reg <= w_state_next;
         r_state_reg <= r_state_next;
         aw_held_reg <= aw_held_next;
         w_held_reg  <= w_held_next;
         awaddr_reg  <= awaddr_next;
         wdata_reg   <= wdata_next;
         bresp_reg   <= bresp_next;
         awready_reg <= awready_next;
         wready_reg  <= wready_next;
         arready_reg <= arready_next;
         rdata_reg   <= rdata_next;
         rresp_reg   <= rresp_next;
         ctrl_reg    <= ctrl_next;
         scratch_reg <= scratch_next;
         count_reg   <= count_reg + 1'b1;
      end
   end

   assign o_AWREADY    = awready_reg;
   assign o_WREADY     = wready_reg;
   assign o_ARREADY    = arready_reg;
   assign o_BVALID     = (w_state_reg == W_RESP);
   assign ov_BRESP     = bresp_reg;
   assign o_RVALID     = (r_state_reg == R_DATA);
   assign ov_RDATA     = rdata_reg;
   assign ov_RRESP     = rresp_reg;
   assign ov_FPGA_TEST = ctrl_reg[7:0];
   assign o_LED        = ctrl_reg[8];
endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder: queued expected responses checked as the DUT answers.
module tb_axil_reg_responder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [15:0] wdata;
   logic [1:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid, led;
   logic [1:0]  bresp, rresp;
   logic [15:0] rdata;
   logic [7:0]  fpga_test;

   int checks = 0;
   int errors = 0;
   logic [1:0]  exp_b[$];
   logic [17:0] exp_r[$];
   logic [15:0] mcount;
   logic [15:0] scr_exp;

   always #5 clk = ~clk;

   // Reference free-running counter: value seen by a read is the count before the AR edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mcount <= 16'h0000;
      else        mcount <= mcount + 16'h0001;
   end

   axil_reg_responder #(.AWIDTH(8), .DWIDTH(16), .ID_VALUE(16'hF1D5)) dut (
      .i_CLK(clk), .i_RESET_n(rst_n),
      .iv_AWADDR(awaddr), .i_AWVALID(awvalid), .o_AWREADY(awready),
      .iv_WDATA(wdata), .iv_WSTRB(wstrb), .i_WVALID(wvalid), .o_WREADY(wready),
      .ov_BRESP(bresp), .o_BVALID(bvalid), .i_BREADY(bready),
      .iv_ARADDR(araddr), .i_ARVALID(arvalid), .o_ARREADY(arready),
      .ov_RDATA(rdata), .ov_RRESP(rresp), .o_RVALID(rvalid), .i_RREADY(rready),
      .ov_FPGA_TEST(fpga_test), .o_LED(led)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves at the negedge after the B handshake.
   task automatic axi_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] strb,
                            input int aw_lead, input int hold, input logic [1:0] eresp);
      int cyc;
      bit aw_done, w_done, aw_fire, w_fire;
      logic [1:0] e;
      exp_b.push_back(eresp);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = (aw_lead == 0);
      cyc = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(negedge clk); cyc++;
         if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
         if (w_fire)  begin wvalid = 1'b0; w_done = 1; end
         if (!w_done && cyc >= aw_lead) wvalid = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("aw_w_accepted", {31'd0, aw_done && w_done}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         check("bvalid_held", {31'd0, bvalid}, 32'd1);
         check("ready_blocked", {30'd0, awready, wready}, 32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      cyc = 0;
      while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
      check("bvalid", {31'd0, bvalid}, 32'd1);
      if (exp_b.size() == 0) check("bresp_queue", 32'd0, 32'd1);
      else begin
         e = exp_b.pop_front();
         $display("write addr=%h data=%h strb=%b bresp=%b", addr, data, strb, bresp);
         check("bresp", {30'd0, bresp}, {30'd0, e});
      end
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_drop", {31'd0, bvalid}, 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int hold, input logic [15:0] edata,
                           input logic [1:0] eresp, input bit use_count);
      int cyc;
      bit fired;
      logic [17:0] e;
      araddr = addr; arvalid = 1'b1;
      cyc = 0; fired = 0;
      while (!fired && cyc < 40) begin
         if (arvalid && arready) begin
            fired = 1;
            exp_r.push_back({use_count ? mcount : edata, eresp});
         end
         @(negedge clk); cyc++;
      end
      arvalid = 1'b0;
      check("ar_accepted", {31'd0, fired}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         check("rvalid_held", {31'd0, rvalid}, 32'd1);
         @(negedge clk);
      end
      rready = 1'b1;
      cyc = 0;
      while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
      check("rvalid", {31'd0, rvalid}, 32'd1);
      if (exp_r.size() == 0) check("rdata_queue", 32'd0, 32'd1);
      else begin
         e = exp_r.pop_front();
         $display("read  addr=%h rdata=%h rresp=%b", addr, rdata, rresp);
         check("rdata", {16'd0, rdata}, {16'd0, e[17:2]});
         check("rresp", {30'd0, rresp}, {30'd0, e[1:0]});
      end
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      @(negedge clk);
      check("reset_ready", {29'd0, awready, wready, arready}, 32'd0);
      check("reset_valid", {30'd0, bvalid, rvalid}, 32'd0);
      check("reset_resp_data", {12'd0, bresp, rresp, rdata}, 32'd0);
      check("reset_pins", {23'd0, led, fpga_test}, 32'd0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
      @(negedge clk);
      check("ready_after_edge", {29'd0, awready, wready, arready}, 32'd7);

      axi_read(8'h00, 0, 16'hF1D5, 2'b00, 0);
      axi_write(8'h02, 16'h01A5, 2'b11, 1, 0, 2'b00);
      check("fpga_test", {24'd0, fpga_test}, 32'h0000_00A5);
      check("led", {31'd0, led}, 32'd1);
      axi_read(8'h02, 0, 16'h01A5, 2'b00, 0);

      axi_write(8'h04, 16'hBEEF, 2'b11, 0, 3, 2'b00);
      axi_read(8'h04, 2, 16'hBEEF, 2'b00, 0);

      axi_write(8'h06, 16'h5A5A, 2'b11, 0, 0, 2'b10);
      axi_read(8'h0A, 0, 16'h0000, 2'b10, 0);
      axi_read(8'h06, 0, 16'h0000, 2'b00, 1);
      axi_read(8'h07, 1, 16'h0000, 2'b00, 1);
      axi_write(8'h00, 16'h1111, 2'b11, 0, 0, 2'b10);
      axi_read(8'h01, 0, 16'hF1D5, 2'b00, 0);
      axi_write(8'h40, 16'h2222, 2'b11, 0, 0, 2'b10);

      axi_write(8'h04, 16'h1234, 2'b01, 0, 0, 2'b00);
`ifdef AXIL_REG_RESPONDER_WSTRB_EN
      scr_exp = 16'hBE34;
`else
      scr_exp = 16'h1234;
`endif
      axi_read(8'h04, 0, scr_exp, 2'b00, 0);

      axi_write(8'h03, 16'hFFFF, 2'b11, 0, 0, 2'b00);
      check("fpga_test_ff", {24'd0, fpga_test}, 32'h0000_00FF);
      axi_read(8'h02, 0, 16'h01FF, 2'b00, 0);

      // Write and read of SCRATCH handshake on the same edge: read sees the old value.
      fork
         axi_write(8'h04, 16'h5555, 2'b11, 0, 0, 2'b00);
         axi_read(8'h04, 0, scr_exp, 2'b00, 0);
      join
      axi_read(8'h04, 0, 16'h5555, 2'b00, 0);

      // Reset while a read response is pending.
      araddr = 8'h00; arvalid = 1'b1; rready = 1'b0;
      cyc = 0;
      while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_pending", {31'd0, rvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_pins", {23'd0, led, fpga_test}, 32'd0);
      check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", {29'd0, awready, wready, arready}, 32'd7);
      axi_read(8'h04, 0, 16'h0000, 2'b00, 0);
      axi_read(8'h02, 0, 16'h0000, 2'b00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
